fetch_sequencer: RTL and testbench

Instruction-fetch controller for the MIPS datapath: owns the program counter and sequences every instruction-memory access, one outstanding request at a time. It presents each fetched word with its address to decode through a valid/ready handshake. It applies branch/jump redirects from execute at any point, discarding stale responses. It sits between the PC/next-PC logic and the instruction memory port, and replaces free-running PC update with a handshaked fetch.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 46 ++++
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: instruction word width, default reset PC
// and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [2:0] {
      FS_IDLE = 3'd0,
      FS_REQ  = 3'd1,
      FS_WAIT = 3'd2,
      FS_DROP = 3'd3,
      FS_HOLD = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch sequencer.
// Ports:
//    clk        rising-edge clock
//    reset      synchronous active-low reset, loads RESET_PC
//    load_i     load load_pc_i (redirect), wins over inc_i
//    load_pc_i  redirect target; low two bits are masked off
//    inc_i      advance pc by 4 (wraps modulo 2^32)
//    pc_o       current pc, always word aligned
module fetch_pc_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_pc_i,
   input  logic            inc_i,
   output logic [XLEN-1:0] pc_o
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i & ALIGN_MASK;
      end else if (inc_i) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC & ALIGN_MASK;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Handshaked instruction-fetch controller: one outstanding imem request,
// fetched word + address presented to decode via valid/ready, redirects
// from execute accepted at any time with stale responses discarded.
// Ports:
//    clk, reset                      clock, synchronous active-low reset
//    redir_valid_i, redir_pc_i       branch/jump redirect from execute
//    imem_req_o, imem_addr_o         instruction memory request
//    imem_gnt_i                      request accepted this cycle
//    imem_rvalid_i, imem_rdata_i     memory response
//    instr_valid_o, instr_o,
//    instr_pc_o, instr_ready_i       decode handshake
//    addr_err_o                      pulse after a misaligned redirect
//    pc_o                            current fetch pc
//
// state | meaning
// IDLE  | post-reset, one cycle before the first request
// REQ   | imem_req_o high, waiting for grant
// WAIT  | granted, waiting for the response to keep
// DROP  | granted response pending but stale (redirected), discard it
// HOLD  | instruction presented to decode, waiting for ready
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redir_valid_i,
   input  logic [XLEN-1:0] redir_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i,
   output logic            addr_err_o,
   output logic [XLEN-1:0] pc_o
);

   fetch_state_e    state_d, state_q;
   logic            imem_req_d, imem_req_q;
   logic            instr_valid_d, instr_valid_q;
   logic [XLEN-1:0] instr_d, instr_q;
   logic [XLEN-1:0] instr_pc_d, instr_pc_q;
   logic            addr_err_d, addr_err_q;
   logic            pc_load;
   logic            pc_inc;
   logic [XLEN-1:0] pc;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .reset     (reset),
      .load_i    (pc_load),
      .load_pc_i (redir_pc_i),
      .inc_i     (pc_inc),
      .pc_o      (pc)
   );

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;

      // Redirect is honoured in every state except IDLE and always wins.
      if (redir_valid_i && (state_q != FS_IDLE)) begin
         pc_load = 1'b1;
      end

      case (state_q)
         FS_IDLE: state_d = FS_REQ;
         FS_REQ: begin
            if (imem_gnt_i) begin
               // A granted request to the old pc must still be drained.
               state_d = pc_load ? FS_DROP : FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (pc_load) begin
               state_d = imem_rvalid_i ? FS_REQ : FS_DROP;
            end else if (imem_rvalid_i) begin
               state_d    = FS_HOLD;
               instr_d    = imem_rdata_i;
               instr_pc_d = pc;
               pc_inc     = 1'b1;
            end
         end
         FS_DROP: begin
            if (imem_rvalid_i) begin
               state_d = FS_REQ;
            end
         end
         FS_HOLD: begin
            if (pc_load || instr_ready_i) begin
               state_d = FS_REQ;
            end
         end
         default: state_d = FS_IDLE;
      endcase

      imem_req_d    = (state_d == FS_REQ);
      instr_valid_d = (state_d == FS_HOLD);
      addr_err_d    = pc_load && (redir_pc_i[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= FS_IDLE;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign imem_req_o    = imem_req_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign addr_err_o    = addr_err_q;
   assign imem_addr_o   = pc;
   assign pc_o          = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The memory model grants every request
// in the same cycle and returns the request address as data after rv_delay
// extra cycles.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        redir_valid_i;
   logic [31:0] redir_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        addr_err_o;
   logic [31:0] pc_o;

   int n_checks = 0;
   int n_errors = 0;
   int rv_delay = 0;
   int rv_cnt   = 0;
   logic [31:0] rv_addr = '0;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .redir_valid_i (redir_valid_i),
      .redir_pc_i    (redir_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .addr_err_o    (addr_err_o),
      .pc_o          (pc_o)
   );

   assign imem_gnt_i = imem_req_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are updated 1 time unit after the edge.
   task automatic cyc();
      logic        g;
      logic [31:0] a;
      g = imem_req_o & imem_gnt_i;
      a = imem_addr_o;
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = rv_addr;
         end
      end
      if (g) begin
         if (rv_delay == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = a;
         end else begin
            rv_cnt  = rv_delay;
            rv_addr = a;
         end
      end
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!instr_valid_o && n < 20);
      if (!instr_valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!imem_req_o && n < 20) begin
         cyc();
         n++;
      end
      if (!imem_req_o) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},  32'(dut.state_q), 32'(FS_IDLE));
      check({tag, "_req"},    32'(imem_req_o), 32'd0);
      check({tag, "_valid"},  32'(instr_valid_o), 32'd0);
      check({tag, "_instr"},  instr_o, 32'h0);
      check({tag, "_ipc"},    instr_pc_o, 32'h0);
      check({tag, "_err"},    32'(addr_err_o), 32'd0);
      check({tag, "_pc"},     pc_o, 32'h0000_3000);
   endtask

   initial begin
      int n;
      reset         = 1'b0;
      redir_valid_i = 1'b0;
      redir_pc_i    = '0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      instr_ready_i = 1'b1;

      // Reset values
      repeat (3) cyc();
      check_reset_outputs("rst");

      // Streaming at peak rate with ready held high
      reset = 1'b1;
      cyc();
      check("s_req", 32'(imem_req_o), 32'd1);
      check("s_addr0", imem_addr_o, 32'h0000_3000);
      wait_valid("s0", n);
      check("s_lat0", 32'(n), 32'd2);
      check("s_ipc0", instr_pc_o, 32'h0000_3000);
      check("s_ins0", instr_o, 32'h0000_3000);
      check("s_pc_inc", pc_o, 32'h0000_3004);
      wait_valid("s1", n);
      check("s_lat1", 32'(n), 32'd3);
      check("s_ipc1", instr_pc_o, 32'h0000_3004);
      check("s_ins1", instr_o, 32'h0000_3004);
      wait_valid("s2", n);
      check("s_lat2", 32'(n), 32'd3);
      check("s_ipc2", instr_pc_o, 32'h0000_3008);

      // Decode stall: hold the instruction for 5 cycles
      instr_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("h_valid", 32'(instr_valid_o), 32'd1);
         check("h_ipc", instr_pc_o, 32'h0000_3008);
         check("h_ins", instr_o, 32'h0000_3008);
         check("h_noreq", 32'(imem_req_o), 32'd0);
      end
      instr_ready_i = 1'b1;
      cyc();
      check("h_resume_req", 32'(imem_req_o), 32'd1);
      check("h_resume_addr", imem_addr_o, 32'h0000_300C);
      wait_valid("h", n);
      check("h_ipc_next", instr_pc_o, 32'h0000_300C);

      // Redirect while waiting on a slow response
      rv_delay = 3;
      cyc();
      check("d_addr", imem_addr_o, 32'h0000_3010);
      cyc();
      check("d_wait", 32'(dut.state_q), 32'(FS_WAIT));
      redir_valid_i = 1'b1;
      redir_pc_i    = 32'h0000_4000;
      cyc();
      redir_valid_i = 1'b0;
      rv_delay      = 0;
      check("d_state", 32'(dut.state_q), 32'(FS_DROP));
      check("d_pc", pc_o, 32'h0000_4000);
      check("d_noreq", 32'(imem_req_o), 32'd0);
      check("d_err", 32'(addr_err_o), 32'd0);
      wait_req("d");
      check("d_req_addr", imem_addr_o, 32'h0000_4000);
      wait_valid("d", n);
      check("d_ipc", instr_pc_o, 32'h0000_4000);
      check("d_ins", instr_o, 32'h0000_4000);

      // Misaligned redirect in HOLD with ready high
      redir_valid_i = 1'b1;
      redir_pc_i    = 32'h0000_5006;
      cyc();
      redir_valid_i = 1'b0;
      check("m_err", 32'(addr_err_o), 32'd1);
      check("m_addr", imem_addr_o, 32'h0000_5004);
      check("m_req", 32'(imem_req_o), 32'd1);
      check("m_valid", 32'(instr_valid_o), 32'd0);
      cyc();
      check("m_err_pulse", 32'(addr_err_o), 32'd0);
      wait_valid("m", n);
      check("m_ipc", instr_pc_o, 32'h0000_5004);

      // Wrap at the top of the address space
      redir_valid_i = 1'b1;
      redir_pc_i    = 32'hFFFF_FFFC;
      cyc();
      redir_valid_i = 1'b0;
      check("w_addr", imem_addr_o, 32'hFFFF_FFFC);
      check("w_err", 32'(addr_err_o), 32'd0);
      wait_valid("w0", n);
      check("w_ipc0", instr_pc_o, 32'hFFFF_FFFC);
      check("w_pc", pc_o, 32'h0000_0000);
      wait_valid("w1", n);
      check("w_ipc1", instr_pc_o, 32'h0000_0000);

      // Reset during WAIT; the late response must be ignored
      cyc();
      check("r_addr", imem_addr_o, 32'h0000_0004);
      rv_delay = 2;
      cyc();
      check("r_wait", 32'(dut.state_q), 32'(FS_WAIT));
      rv_delay = 0;
      reset    = 1'b0;
      cyc();
      check_reset_outputs("r");
      reset = 1'b1;
      cyc();
      check("r_late_rvalid", 32'(imem_rvalid_i), 32'd1);
      check("r_req", 32'(imem_req_o), 32'd1);
      check("r_req_addr", imem_addr_o, 32'h0000_3000);
      cyc();
      check("r_after_late", 32'(dut.state_q), 32'(FS_WAIT));
      check("r_no_valid", 32'(instr_valid_o), 32'd0);
      wait_valid("r", n);
      check("r_ipc", instr_pc_o, 32'h0000_3000);
      check("r_ins", instr_o, 32'h0000_3000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
